// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: receives the (x, y, colour, writeEn) plot stream from the
// note-drawing blocks. Plots are queued in a small FIFO and committed to an
// internal 160x120x3 framebuffer. A row-major scan-out port with a
// request/valid handshake feeds the VGA output stage.
// The framebuffer is single-ported and display reads always win, so queued
// plots drain only in cycles without a read request.
module vga_pixel_sink #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       writeEn,
  output logic       wr_full,
  output logic       overflow,
  output logic [7:0] drop_count,
  input  logic       rd_req,
  output logic       rd_valid,
  output logic [2:0] rd_colour,
  output logic [7:0] rd_x,
  output logic [6:0] rd_y,
  output logic       frame_start
);

  localparam int FB_DEPTH = WIDTH * HEIGHT;
  localparam int ADDR_W   = 15;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [7:0]       X_LIM  = 8'(WIDTH);
  localparam logic [6:0]       Y_LIM  = 7'(HEIGHT);
  localparam logic [7:0]       X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0]       Y_LAST = 7'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } plot_t;

  // Linear framebuffer address. For the standard 160-wide screen the multiply
  // becomes two shifts and an add: y*160 = y*128 + y*32.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [7:0] ax,
                                                  input logic [6:0] ay);
    logic [ADDR_W-1:0] yw;
    logic [ADDR_W-1:0] xw;
    yw = {8'd0, ay};
    xw = {7'd0, ax};
    if (WIDTH == 160) return (yw << 7) + (yw << 5) + xw;
    else              return yw * ADDR_W'(WIDTH) + xw;
  endfunction

  // Storage
  plot_t      fifo_mem [FIFO_DEPTH];
  logic [2:0] fb       [FB_DEPTH];

  // State
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q;
  logic [7:0]       drop_count_q, drop_count_d;
  logic [7:0]       scan_x_q, scan_x_d;
  logic [6:0]       scan_y_q, scan_y_d;
  logic             rd_valid_q;
  logic [2:0]       rd_colour_q;
  logic [7:0]       rd_x_q;
  logic [6:0]       rd_y_q;
  logic             frame_start_q;

  // Per-cycle decisions
  logic              in_range, full, pop, push, drop, ovf_hit;
  plot_t             head;
  logic [ADDR_W-1:0] wr_addr, scan_addr;

  // Write-side arbitration, FIFO bookkeeping and scan pointer advance.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    in_range     = (x < X_LIM) && (y < Y_LIM);
    full         = (count_q == CNT_FULL);
    // Pop is suppressed on the reset cycle so no framebuffer write slips through.
    pop          = clear && !rd_req && (count_q != '0);
    push         = clear && writeEn && in_range && (!full || pop);
    drop         = writeEn && (!in_range || (full && !pop));
    ovf_hit      = writeEn && in_range && full && !pop;
    head         = fifo_mem[rd_ptr_q];
    wr_addr      = calc_addr(head.px, head.py);
    scan_addr    = calc_addr(scan_x_q, scan_y_q);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;

    scan_x_d = scan_x_q + 8'd1;
    scan_y_d = scan_y_q;
    if (scan_x_q == X_LAST) begin
      scan_x_d = 8'd0;
      scan_y_d = (scan_y_q == Y_LAST) ? 7'd0 : scan_y_q + 7'd1;
    end
  end

  assign wr_full     = full;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;
  assign rd_valid    = rd_valid_q;
  assign rd_colour   = rd_colour_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign frame_start = frame_start_q;

  // FIFO payload storage; only the pointers and count need resetting.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (push) fifo_mem[wr_ptr_q] <= '{px: x, py: y, pc: colour};
  end

  // Framebuffer commit of the FIFO head in read-free cycles.
  always_ff @(posedge clk) begin
    // NOTE: the framebuffer is deliberately never reset so it maps onto block RAM.
    if (pop) fb[wr_addr] <= head.pc;
  end

  // Control state: FIFO pointers, drop tracking and the registered scan-out port.
  always_ff @(posedge clk) begin
    if (!clear) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      drop_count_q  <= 8'd0;
      scan_x_q      <= 8'd0;
      scan_y_q      <= 7'd0;
      rd_valid_q    <= 1'b0;
      rd_colour_q   <= 3'd0;
      rd_x_q        <= 8'd0;
      rd_y_q        <= 7'd0;
      frame_start_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
      if (ovf_hit) overflow_q <= 1'b1;

      rd_valid_q    <= rd_req;
      frame_start_q <= rd_req && (scan_x_q == 8'd0) && (scan_y_q == 7'd0);
      if (rd_req) begin
        rd_colour_q <= fb[scan_addr];
        rd_x_q      <= scan_x_q;
        rd_y_q      <= scan_y_q;
        scan_x_q    <= scan_x_d;
        scan_y_q    <= scan_y_d;
      end
    end
  end

endmodule
